// File: rtl/i2c_req_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// i2c_req_arbiter_pkg : FSM encoding and default widths for the I2C arbiter
// Rev 1.0
// =============================================================================
package i2c_req_arbiter_pkg;

   localparam int c_STATE_W  = 2;
   localparam int c_ADDR_LEN = 7;
   localparam int c_DATA_LEN = 8;

   typedef enum logic [c_STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_req_arbiter_rr_arbiter.sv
`default_nettype none
// =============================================================================
// rr_arbiter : combinational round-robin pick, search starts at ptr and wraps
// Rev 1.0
// =============================================================================
module rr_arbiter
   import i2c_req_arbiter_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);

   logic             w_found;
   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_idx;

   // One spare bit on the sum so ptr+k never overflows before the wrap
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      w_sum     = '0;
      w_idx     = '0;
      for (int k = 0; k < N; k++) begin
         w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(N)) begin
            w_sum = w_sum - (IDX_W+1)'(N);
         end
         w_idx = w_sum[IDX_W-1:0];
         if (!w_found && req[w_idx]) begin
            w_found        = 1'b1;
            grant[w_idx]   = 1'b1;
            grant_idx      = w_idx;
         end
      end
   end

   assign any = |req;

endmodule
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// =============================================================================
// i2c_req_arbiter : shares one I2C master among NUM_REQ requesters, with watchdog
// Rev 1.0
// =============================================================================
module i2c_req_arbiter
   import i2c_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_LEN       = c_ADDR_LEN,
   parameter int DATA_LEN       = c_DATA_LEN,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*ADDR_LEN-1:0]  req_addr,
   input  logic [NUM_REQ-1:0]           req_rw,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [DATA_LEN-1:0]          rsp_rdata,
   output logic                         rsp_nack,
   output logic                         rsp_timeout,
   output logic                         m_start,
   output logic [ADDR_LEN-1:0]          m_addr,
   output logic                         m_rw,
   output logic [DATA_LEN-1:0]          m_wdata,
   output logic                         m_abort,
   input  logic                         m_busy,
   input  logic                         m_done,
   input  logic [DATA_LEN-1:0]          m_rdata,
   input  logic                         m_nack
);

   localparam int                  c_PTR_W    = $clog2(NUM_REQ);
   localparam int                  c_WD_W     = $clog2(TIMEOUT_CYCLES+1);
   localparam logic [c_WD_W-1:0]   c_WD_LAST  = c_WD_W'(TIMEOUT_CYCLES-1);
   localparam logic [c_PTR_W-1:0]  c_PTR_LAST = c_PTR_W'(NUM_REQ-1);
   localparam logic [NUM_REQ-1:0]  c_ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

   logic [ADDR_LEN-1:0] w_addr  [NUM_REQ];
   logic [DATA_LEN-1:0] w_wdata [NUM_REQ];
   logic [NUM_REQ-1:0]  w_grant;
   logic [c_PTR_W-1:0]  w_gnt_idx;
   logic                w_any;

   state_t              r_state;
   logic [c_PTR_W-1:0]  r_rr_ptr;
   logic [c_PTR_W-1:0]  r_gnt_idx;
   logic [c_WD_W-1:0]   r_wd_cnt;
   logic [NUM_REQ-1:0]  r_req_ready;
   logic [NUM_REQ-1:0]  r_rsp_valid;
   logic [DATA_LEN-1:0] r_rsp_rdata;
   logic                r_rsp_nack;
   logic                r_rsp_timeout;
   logic                r_m_start;
   logic [ADDR_LEN-1:0] r_m_addr;
   logic                r_m_rw;
   logic [DATA_LEN-1:0] r_m_wdata;
   logic                r_m_abort;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign w_addr[i]  = req_addr[i*ADDR_LEN +: ADDR_LEN];
      assign w_wdata[i] = req_wdata[i*DATA_LEN +: DATA_LEN];
   end

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (c_PTR_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (r_rr_ptr),
      .grant     (w_grant),
      .grant_idx (w_gnt_idx),
      .any       (w_any)
   );

   // Response fields are loaded on WAIT exit so rsp_valid shows in the RESP cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_rr_ptr      <= '0;
         r_gnt_idx     <= '0;
         r_wd_cnt      <= '0;
         r_req_ready   <= '0;
         r_rsp_valid   <= '0;
         r_rsp_rdata   <= '0;
         r_rsp_nack    <= 1'b0;
         r_rsp_timeout <= 1'b0;
         r_m_start     <= 1'b0;
         r_m_addr      <= '0;
         r_m_rw        <= 1'b0;
         r_m_wdata     <= '0;
         r_m_abort     <= 1'b0;
      end else begin
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         r_m_start   <= 1'b0;
         r_m_abort   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any && !m_busy) begin
                  r_gnt_idx   <= w_gnt_idx;
                  r_m_addr    <= w_addr[w_gnt_idx];
                  r_m_rw      <= req_rw[w_gnt_idx];
                  r_m_wdata   <= w_wdata[w_gnt_idx];
                  r_req_ready <= w_grant;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_m_start <= 1'b1;
               r_wd_cnt  <= '0;
               r_state   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (m_done) begin
                  r_rsp_valid   <= c_ONE << r_gnt_idx;
                  r_rsp_rdata   <= m_rdata;
                  r_rsp_nack    <= m_nack;
                  r_rsp_timeout <= 1'b0;
                  r_state       <= ST_RESP;
               end else if (r_wd_cnt == c_WD_LAST) begin
                  r_m_abort     <= 1'b1;
                  r_rsp_valid   <= c_ONE << r_gnt_idx;
                  r_rsp_rdata   <= '0;
                  r_rsp_nack    <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  r_state       <= ST_RESP;
               end else begin
                  r_wd_cnt <= r_wd_cnt + 1'b1;
               end
            end
            ST_RESP: begin
               r_rr_ptr <= (r_gnt_idx == c_PTR_LAST) ? '0 : r_gnt_idx + 1'b1;
               r_state  <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_nack    = r_rsp_nack;
   assign rsp_timeout = r_rsp_timeout;
   assign m_start     = r_m_start;
   assign m_addr      = r_m_addr;
   assign m_rw        = r_m_rw;
   assign m_wdata     = r_m_wdata;
   assign m_abort     = r_m_abort;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// =============================================================================
// tb_i2c_req_arbiter : directed bench; instance a (long watchdog), b (16 cycles)
// Rev 1.0
// =============================================================================
module tb_i2c_req_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  rv_a, rv_b;
   logic [27:0] req_addr;
   logic [3:0]  req_rw;
   logic [31:0] req_wdata;
   logic        m_busy, m_done, m_nack;
   logic [7:0]  m_rdata;

   logic [3:0]  a_ready, a_rsp_valid, b_ready, b_rsp_valid;
   logic [7:0]  a_rsp_rdata, b_rsp_rdata, a_m_wdata, b_m_wdata;
   logic        a_rsp_nack, a_rsp_timeout, a_m_start, a_m_rw, a_m_abort;
   logic        b_rsp_nack, b_rsp_timeout, b_m_start, b_m_rw, b_m_abort;
   logic [6:0]  a_m_addr, b_m_addr;

   int errors = 0;
   int checks = 0;

   i2c_req_arbiter u_dut_a (
      .clk(clk), .rst(rst), .req_valid(rv_a), .req_ready(a_ready),
      .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_nack(a_rsp_nack),
      .rsp_timeout(a_rsp_timeout), .m_start(a_m_start), .m_addr(a_m_addr),
      .m_rw(a_m_rw), .m_wdata(a_m_wdata), .m_abort(a_m_abort), .m_busy(m_busy),
      .m_done(m_done), .m_rdata(m_rdata), .m_nack(m_nack)
   );

   i2c_req_arbiter #(.TIMEOUT_CYCLES(16)) u_dut_b (
      .clk(clk), .rst(rst), .req_valid(rv_b), .req_ready(b_ready),
      .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_nack(b_rsp_nack),
      .rsp_timeout(b_rsp_timeout), .m_start(b_m_start), .m_addr(b_m_addr),
      .m_rw(b_m_rw), .m_wdata(b_m_wdata), .m_abort(b_m_abort), .m_busy(m_busy),
      .m_done(m_done), .m_rdata(m_rdata), .m_nack(m_nack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input logic sel_b, input logic [3:0] exp, input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (((sel_b ? b_ready : a_ready) == 4'd0) && n < 20);
      chk(tag, sel_b ? b_ready : a_ready, exp);
   endtask

   initial begin
      logic [3:0] exp_g [5];
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

      rst = 1'b1; rv_a = '0; rv_b = '0; req_rw = '0;
      m_busy = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         req_addr[i*7 +: 7]  = 7'(16 + i);
         req_wdata[i*8 +: 8] = 8'(160 + i);
      end
      tick(); tick();
      chk("rst_ready",   32'(a_ready), 0);
      chk("rst_rsp",     32'(a_rsp_valid), 0);
      chk("rst_start",   32'(a_m_start), 0);
      chk("rst_addr",    32'(a_m_addr), 0);
      chk("rst_abort",   32'(a_m_abort), 0);
      rst = 1'b0;

      // Fairness: all four requesters pending from rr_ptr 0
      rv_a = 4'hF;
      for (int n = 0; n < 5; n++) begin
         wait_ready(1'b0, exp_g[n], "rr_grant");
         tick();
         chk("rr_start", 32'(a_m_start), 1);
         chk("rr_addr",  32'(a_m_addr), 32'(16 + (n % 4)));
         tick();
         m_done = 1'b1; m_rdata = 8'(16 + n);
         tick();
         m_done = 1'b0;
         chk("rr_rsp",   32'(a_rsp_valid), 32'(exp_g[n]));
         chk("rr_rdata", 32'(a_rsp_rdata), 32'(16 + n));
      end
      rv_a = '0;
      tick();

      // Single write to requester 2, first held off by m_busy
      req_addr[14 +: 7]  = 7'h50;
      req_wdata[16 +: 8] = 8'hA5;
      rv_a = 4'b0100; m_busy = 1'b1;
      tick();
      chk("busy_block", 32'(a_ready), 0);
      m_busy = 1'b0;
      tick();
      chk("wr_ready", 32'(a_ready), 32'h4);
      rv_a = '0;
      tick();
      chk("wr_start", 32'(a_m_start), 1);
      chk("wr_addr",  32'(a_m_addr), 32'h50);
      chk("wr_wdata", 32'(a_m_wdata), 32'hA5);
      chk("wr_rw",    32'(a_m_rw), 0);
      tick();
      chk("wr_start_pulse", 32'(a_m_start), 0);
      repeat (19) tick();
      m_done = 1'b1; m_nack = 1'b0; m_rdata = 8'h77;
      tick();
      m_done = 1'b0;
      chk("wr_rsp",     32'(a_rsp_valid), 32'h4);
      chk("wr_nack",    32'(a_rsp_nack), 0);
      chk("wr_timeout", 32'(a_rsp_timeout), 0);
      tick();
      chk("wr_rsp_pulse", 32'(a_rsp_valid), 0);

      // Read from requester 1 with NACK; rr_ptr now 3
      req_addr[7 +: 7] = 7'h21;
      req_rw = 4'b0010;
      rv_a = 4'b0010;
      wait_ready(1'b0, 4'b0010, "rd_ready");
      rv_a = '0;
      tick();
      chk("rd_start", 32'(a_m_start), 1);
      chk("rd_rw",    32'(a_m_rw), 1);
      chk("rd_addr",  32'(a_m_addr), 32'h21);
      tick(); tick();
      m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'h3C;
      tick();
      m_done = 1'b0; m_nack = 1'b0;
      chk("rd_rsp",   32'(a_rsp_valid), 32'h2);
      chk("rd_nack",  32'(a_rsp_nack), 1);
      chk("rd_rdata", 32'(a_rsp_rdata), 32'h3C);
      req_rw = '0;

      // Reset while waiting on the master
      rv_a = 4'b1000;
      wait_ready(1'b0, 4'b1000, "rs_ready");
      rv_a = '0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk("rs_start", 32'(a_m_start), 0);
      chk("rs_addr",  32'(a_m_addr), 0);
      chk("rs_nack",  32'(a_rsp_nack), 0);
      chk("rs_rdata", 32'(a_rsp_rdata), 0);
      tick();
      rst = 1'b0;
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      chk("rs_no_rsp", 32'(a_rsp_valid), 0);
      chk("rs_idle",   32'(a_m_start), 0);
      rv_a = 4'b1010;
      wait_ready(1'b0, 4'b0010, "rs_ptr0_grant");
      rv_a = 4'b1000;
      tick(); tick();
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      chk("rs_rsp1", 32'(a_rsp_valid), 32'h2);
      wait_ready(1'b0, 4'b1000, "rs_grant3");
      rv_a = '0;
      tick(); tick();
      m_done = 1'b1;
      tick();
      m_done = 1'b0;
      chk("rs_rsp3", 32'(a_rsp_valid), 32'h8);

      // Watchdog expiry on instance b (16 cycles)
      rv_b = 4'b0001;
      wait_ready(1'b1, 4'b0001, "to_ready");
      rv_b = '0;
      tick();
      chk("to_start", 32'(b_m_start), 1);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("to_no_abort", 32'({b_m_abort, b_rsp_valid}), 0);
      end
      tick();
      chk("to_abort",   32'(b_m_abort), 1);
      chk("to_rsp",     32'(b_rsp_valid), 32'h1);
      chk("to_timeout", 32'(b_rsp_timeout), 1);
      chk("to_nack",    32'(b_rsp_nack), 1);
      chk("to_rdata",   32'(b_rsp_rdata), 0);
      tick();
      chk("to_abort_pulse", 32'(b_m_abort), 0);
      chk("to_hold",        32'(b_rsp_timeout), 1);

      // m_done on the expiry cycle wins
      rv_b = 4'b0010;
      wait_ready(1'b1, 4'b0010, "co_ready");
      rv_b = '0;
      tick();
      chk("co_start", 32'(b_m_start), 1);
      repeat (15) tick();
      m_done = 1'b1; m_nack = 1'b0; m_rdata = 8'h5A;
      tick();
      m_done = 1'b0;
      chk("co_abort",   32'(b_m_abort), 0);
      chk("co_rsp",     32'(b_rsp_valid), 32'h2);
      chk("co_timeout", 32'(b_rsp_timeout), 0);
      chk("co_nack",    32'(b_rsp_nack), 0);
      chk("co_rdata",   32'(b_rsp_rdata), 32'h5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
